// File: rtl/kgp_rf_pkg.sv
// Shared constants and reset-load helper for the KGP-RISC register file.
package kgp_rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum int {
        RF_INIT_ZERO  = 0,
        RF_INIT_INDEX = 1
    } rf_init_e;

    // Reset value of register idx; callers truncate to their data width.
    function automatic logic [31:0] rf_init_val(input int unsigned idx, input int mode);
        return (mode == int'(RF_INIT_INDEX)) ? idx : 32'd0;
    endfunction

endpackage

// File: rtl/kgp_rf_read_port.sv
// One combinational read port: array select, write bypass, zero-register force
// and operand-ready flag from the busy scoreboard.
module kgp_rf_read_port #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     data,
    output logic                  ready
);

    logic is_zero;
    logic hit;

    always_comb begin
        is_zero = ZERO_REG && (addr == '0);
        hit     = wr_en && (wr_addr == addr) && !is_zero;
        data    = mem[addr];
        if (hit)
            data = wr_data;
        if (is_zero)
            data = '0;
        ready = is_zero || !busy[addr] || hit;
    end

endmodule

// File: rtl/kgp_regfile.sv
// Parametrised multi-read-port register file with write bypass, optional
// hardwired zero register and a busy-bit scoreboard for long-latency producers.
module kgp_regfile
    import kgp_rf_pkg::*;
#(
    parameter int unsigned DATA_W    = RF_DATA_W,
    parameter int unsigned ADDR_W    = RF_ADDR_W,
    parameter int unsigned NUM_RD    = 2,
    parameter bit          ZERO_REG  = 1'b1,
    parameter int          INIT_MODE = int'(RF_INIT_INDEX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          write_register,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    output logic [NUM_RD-1:0]          read_ready,
    input  logic                       set_busy,
    input  logic [ADDR_W-1:0]          busy_reg,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_en;
    logic              set_en;
    logic              bypass_en;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wr_en     = reg_write && !(ZERO_REG && (write_register == '0));
    assign set_en    = set_busy && !(ZERO_REG && (busy_reg == '0));
    // Bypass is suppressed during reset so reads show the freshly loaded contents.
    assign bypass_en = reg_write && !rst;

    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[write_register] = 1'b0;
        if (set_en)
            busy_nxt[busy_reg] = 1'b1;
        cnt_inc = set_en && !busy[busy_reg];
        cnt_dec = wr_en && busy[write_register] && !(set_en && (busy_reg == write_register));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(rf_init_val(i, INIT_MODE));
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en)
                mem[write_register] <= write_data;
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        kgp_rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr    (read_reg[p*ADDR_W +: ADDR_W]),
            .mem     (mem),
            .busy    (busy),
            .wr_en   (bypass_en),
            .wr_addr (write_register),
            .wr_data (write_data),
            .data    (read_data[p*DATA_W +: DATA_W]),
            .ready   (read_ready[p])
        );
    end

endmodule

// File: doc/kgp_regfile.md
# kgp_regfile

Parametrised successor to the processor's two-read, one-write register file: configurable data width, depth and read-port count, plus four additions. It has an asynchronous reset, an optional hardwired-zero register, and write-to-read bypass. It also keeps a busy-bit scoreboard so the decode stage can stall on operands that a multi-cycle unit has not yet produced. It sits between decode (read and reserve ports) and writeback (write port) in the KGP-RISC datapath.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2: number of read ports (1..4)
- ZERO_REG, 1: 1 makes register 0 always read 0; writes and reserves to it are ignored
- INIT_MODE, 1: reset contents; 0 sets every register to 0, 1 sets register i to i

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- reg_write  in  1  write enable
- write_register  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- read_reg  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  read data; port p uses bits [p*DATA_W +: DATA_W]
- read_ready  out  NUM_RD  port p operand is valid this cycle
- set_busy  in  1  reserve a destination register (issue of a long-latency op)
- busy_reg  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Write: at the rising clk edge, if reg_write=1, RF[write_register] <= write_data. When ZERO_REG=1 and write_register=0, the write is dropped.
- Read data is combinational. Port p outputs RF[a] with a = read_reg[p]. If reg_write=1 and write_register=a (and a is not the zero register), the port outputs write_data instead (bypass). The zero register reads 0 when ZERO_REG=1.
- Scoreboard: one busy bit per register.
  - At the clock edge, set_busy=1 sets busy[busy_reg].
  - At the clock edge, reg_write=1 clears busy[write_register].
  - If both target the same register in the same cycle, set wins: the bit stays 1, because a new producer has been issued.
  - Reserves to register 0 are ignored when ZERO_REG=1.
- read_ready[p] = !busy[a] || (reg_write && write_register==a). The zero register is always ready.
- busy_cnt tracks the population of the busy bits:
  - +1 on a set of a bit that was clear.
  - −1 on a clear of a bit that was set.
  - Net 0 when both happen on different registers, or when nothing changes.
  - Never wraps: the maximum is DEPTH (DEPTH−1 when ZERO_REG=1).
- Reset (asynchronous, any time, including mid-write):
  - Array is loaded per INIT_MODE. With INIT_MODE=1, register i holds i truncated to DATA_W; register 0 holds 0.
  - All busy bits are cleared and busy_cnt = 0.
  - Any write presented in the reset cycle is lost.
- Output values during reset:
  - read_data = init value of the addressed register (0 for the zero register).
  - read_ready = all 1s.
  - busy_cnt = 0.
- No FSM. State is the array, the busy vector and busy_cnt.

## Timing
- Write-to-read latency is 0 cycles via bypass. From the following cycle the value comes from the array.
- Reserve takes effect the cycle after set_busy: read_ready for that register drops at the next edge.
- A write clears busy at the edge. read_ready is already high during the write cycle via the bypass term.
- busy_cnt updates at the same edge as the busy bits.
- Reset assertion takes effect immediately. Deassertion is synchronised by the integrator; the block is usable at the first edge after deassertion.
- All read ports are independent and may alias the same address.

## Structure
- Package kgp_rf_pkg holds:
  - the default DATA_W/ADDR_W constants;
  - the INIT_MODE encodings (RF_INIT_ZERO=0, RF_INIT_INDEX=1);
  - function rf_init_val(idx) used for reset load.
- Sub-module kgp_rf_read_port: one read port covering the address decode, bypass compare, zero-register force and read_ready logic. It is instantiated NUM_RD times in a generate loop.
- The array, busy vector and counter live in kgp_regfile.

## Test plan
- Reset, INIT_MODE=1, ZERO_REG=1: read_reg = {5, 0} gives read_data = {5, 0}, read_ready = 2'b11, busy_cnt = 0.
- Write 32'hDEADBEEF to r7 while port 0 reads r7: same cycle read_data[0] = DEADBEEF via bypass; next cycle still DEADBEEF from the array.
- Write 32'h1234 to r0 with ZERO_REG=1: r0 reads 0 that cycle and every later cycle.
- set_busy r3, then port 1 reads r3: read_ready[1]=0 and busy_cnt=1 from the next cycle. A later write of 32'hAA to r3 gives ready=1 with data AA in the write cycle, and busy_cnt=0 after it.
- Same-cycle set_busy r4 and write r4: data updates, busy[4] stays 1, busy_cnt increments by 1. Same-cycle set r5 and clear of busy r6: busy_cnt unchanged.
- Assert rst asynchronously mid-cycle with r9 busy and a write pending: busy_cnt = 0 and r9 = 9 immediately; the pending write never lands.
